// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates the single register-file write port
// between ALU, load-return and link (jal) writeback sources. Each source owns
// a one-entry holding register; one held source is granted per cycle using
// fixed priority LNK > LD > ALU, overridden by per-source starvation aging.
module regfile_write_scheduler #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_add,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_add,
  input  logic [31:0] ld_data,
  input  logic        lnk_valid,
  output logic        lnk_ready,
  input  logic [31:0] lnk_data,
  output logic        WE_reg,
  output logic        ra_enable,
  output logic [4:0]  rd_add,
  output logic [31:0] rd_data,
  output logic [31:0] ra_data,
  input  logic [4:0]  rs_q,
  input  logic [4:0]  rt_q,
  output logic        rs_pending,
  output logic        rt_pending
);

  localparam logic [3:0] MaxW    = 4'(MAX_WAIT);
  localparam logic [4:0] LinkReg = 5'd31;

  // Source slots within the packed per-source vectors.
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LD  = 2'd1,
    SRC_LNK = 2'd2
  } src_e;

  // Holding registers
  logic [2:0]       held_q, held_d;
  logic [4:0]       alu_add_q, alu_add_d;
  logic [31:0]      alu_data_q, alu_data_d;
  logic [4:0]       ld_add_q, ld_add_d;
  logic [31:0]      ld_data_q, ld_data_d;
  logic [31:0]      lnk_data_q, lnk_data_d;
  logic [2:0][3:0]  wait_q, wait_d;

  // Output stage
  logic             we_reg_q, we_reg_d;
  logic             ra_enable_q, ra_enable_d;
  logic [4:0]       rd_add_q, rd_add_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      ra_data_q, ra_data_d;

  logic [2:0]       starve;
  logic [2:0]       cand;
  logic [2:0]       grant;

  // Arbitration: starving sources form the candidate set when any exist,
  // otherwise all held sources do; base priority then picks one.
  always_comb begin
    starve = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      starve[i] = held_q[i] & (wait_q[i] == MaxW);
    end
    cand  = (|starve) ? starve : held_q;
    grant = '0;
    if (cand[SRC_LNK])      grant[SRC_LNK] = 1'b1;
    else if (cand[SRC_LD])  grant[SRC_LD]  = 1'b1;
    else if (cand[SRC_ALU]) grant[SRC_ALU] = 1'b1;
  end

  // Ready allows a same-cycle release and recapture.
  always_comb begin
    alu_ready = ~held_q[SRC_ALU] | grant[SRC_ALU];
    ld_ready  = ~held_q[SRC_LD]  | grant[SRC_LD];
    lnk_ready = ~held_q[SRC_LNK] | grant[SRC_LNK];
  end

  // Holding-register next state: release on grant, then capture on handshake.
  always_comb begin
    held_d     = held_q & ~grant;
    alu_add_d  = alu_add_q;
    alu_data_d = alu_data_q;
    ld_add_d   = ld_add_q;
    ld_data_d  = ld_data_q;
    lnk_data_d = lnk_data_q;
    if (alu_valid & alu_ready) begin
      held_d[SRC_ALU] = 1'b1;
      alu_add_d       = alu_add;
      alu_data_d      = alu_data;
    end
    if (ld_valid & ld_ready) begin
      held_d[SRC_LD] = 1'b1;
      ld_add_d       = ld_add;
      ld_data_d      = ld_data;
    end
    if (lnk_valid & lnk_ready) begin
      held_d[SRC_LNK] = 1'b1;
      lnk_data_d      = lnk_data;
    end
  end

  // Aging counters: count lost cycles while held, saturate at MAX_WAIT.
  always_comb begin
    wait_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (held_q[i] & ~grant[i]) begin
        wait_d[i] = (wait_q[i] >= MaxW) ? MaxW : wait_q[i] + 4'd1;
      end
    end
  end

  // Output stage next state from the current grant; $0 writes are dropped.
  always_comb begin
    we_reg_d    = 1'b0;
    ra_enable_d = 1'b0;
    rd_add_d    = '0;
    rd_data_d   = '0;
    ra_data_d   = '0;
    if (grant[SRC_LNK]) begin
      we_reg_d    = 1'b1;
      ra_enable_d = 1'b1;
      rd_add_d    = LinkReg;
      ra_data_d   = lnk_data_q;
    end else if (grant[SRC_LD]) begin
      we_reg_d  = (ld_add_q != 5'd0);
      rd_add_d  = ld_add_q;
      rd_data_d = ld_data_q;
    end else if (grant[SRC_ALU]) begin
      we_reg_d  = (alu_add_q != 5'd0);
      rd_add_d  = alu_add_q;
      rd_data_d = alu_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= '0;
      alu_add_q   <= '0;
      alu_data_q  <= '0;
      ld_add_q    <= '0;
      ld_data_q   <= '0;
      lnk_data_q  <= '0;
      wait_q      <= '0;
      we_reg_q    <= 1'b0;
      ra_enable_q <= 1'b0;
      rd_add_q    <= '0;
      rd_data_q   <= '0;
      ra_data_q   <= '0;
    end else begin
      held_q      <= held_d;
      alu_add_q   <= alu_add_d;
      alu_data_q  <= alu_data_d;
      ld_add_q    <= ld_add_d;
      ld_data_q   <= ld_data_d;
      lnk_data_q  <= lnk_data_d;
      wait_q      <= wait_d;
      we_reg_q    <= we_reg_d;
      ra_enable_q <= ra_enable_d;
      rd_add_q    <= rd_add_d;
      rd_data_q   <= rd_data_d;
      ra_data_q   <= ra_data_d;
    end
  end

  // Pending query from registered state only.
  always_comb begin
    rs_pending = (rs_q != 5'd0) &
                 ((held_q[SRC_ALU] & (alu_add_q == rs_q)) |
                  (held_q[SRC_LD]  & (ld_add_q  == rs_q)) |
                  (held_q[SRC_LNK] & (LinkReg   == rs_q)) |
                  (we_reg_q        & (rd_add_q  == rs_q)));
    rt_pending = (rt_q != 5'd0) &
                 ((held_q[SRC_ALU] & (alu_add_q == rt_q)) |
                  (held_q[SRC_LD]  & (ld_add_q  == rt_q)) |
                  (held_q[SRC_LNK] & (LinkReg   == rt_q)) |
                  (we_reg_q        & (rd_add_q  == rt_q)));
  end

  assign WE_reg    = we_reg_q;
  assign ra_enable = ra_enable_q;
  assign rd_add    = rd_add_q;
  assign rd_data   = rd_data_q;
  assign ra_data   = ra_data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with hand-computed expectations.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, lnk_valid = 1'b0;
  logic        alu_ready, ld_ready, lnk_ready;
  logic [4:0]  alu_add = '0, ld_add = '0;
  logic [31:0] alu_data = '0, ld_data = '0, lnk_data = '0;
  logic        WE_reg, ra_enable;
  logic [4:0]  rd_add;
  logic [31:0] rd_data, ra_data;
  logic [4:0]  rs_q = '0, rt_q = '0;
  logic        rs_pending, rt_pending;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_scheduler #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_add(alu_add), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_add(ld_add), .ld_data(ld_data),
    .lnk_valid(lnk_valid), .lnk_ready(lnk_ready), .lnk_data(lnk_data),
    .WE_reg(WE_reg), .ra_enable(ra_enable), .rd_add(rd_add), .rd_data(rd_data),
    .ra_data(ra_data), .rs_q(rs_q), .rt_q(rt_q),
    .rs_pending(rs_pending), .rt_pending(rt_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (WE_reg !== 1'b0 || ra_enable !== 1'b0 || rd_add !== 5'd0) begin n_err++; $display("FAIL reset_ctl we=%b ra_en=%b rd_add=%0d want 0/0/0", WE_reg, ra_enable, rd_add); end
    n_vec++; if (rd_data !== 32'd0 || ra_data !== 32'd0) begin n_err++; $display("FAIL reset_data rd_data=%h ra_data=%h want 0/0", rd_data, ra_data); end
    n_vec++; if ({alu_ready, ld_ready, lnk_ready} !== 3'b111) begin n_err++; $display("FAIL reset_ready got %b want 111", {alu_ready, ld_ready, lnk_ready}); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_add = 5'd5; alu_data = 32'hDEADBEEF; rs_q = 5'd5; rt_q = 5'd5;
    #1;
    n_vec++; if (rs_pending !== 1'b0) begin n_err++; $display("FAIL single_pend_pre got %b want 0", rs_pending); end
    step(); // E0
    alu_valid = 1'b0;
    n_vec++; if (rs_pending !== 1'b1 || rt_pending !== 1'b1 || WE_reg !== 1'b0) begin n_err++; $display("FAIL single_e0 rs=%b rt=%b we=%b want 1/1/0", rs_pending, rt_pending, WE_reg); end
    step(); // E1
    n_vec++; if (WE_reg !== 1'b1 || rd_add !== 5'd5 || ra_enable !== 1'b0) begin n_err++; $display("FAIL single_e1_ctl we=%b rd_add=%0d ra_en=%b want 1/5/0", WE_reg, rd_add, ra_enable); end
    n_vec++; if (rd_data !== 32'hDEADBEEF || ra_data !== 32'd0) begin n_err++; $display("FAIL single_e1_data rd=%h ra=%h want deadbeef/0", rd_data, ra_data); end
    n_vec++; if (rs_pending !== 1'b1) begin n_err++; $display("FAIL single_e1_pend got %b want 1", rs_pending); end
    step(); // E2
    n_vec++; if (WE_reg !== 1'b0 || rs_pending !== 1'b0 || rd_data !== 32'd0) begin n_err++; $display("FAIL single_e2 we=%b pend=%b rd=%h want 0/0/0", WE_reg, rs_pending, rd_data); end
    rs_q = '0; rt_q = '0;
  endtask

  task automatic test_all_three();
    alu_valid = 1'b1; alu_add = 5'd3; alu_data = 32'hA1A1A1A1;
    ld_valid = 1'b1;  ld_add = 5'd4;  ld_data = 32'hB2B2B2B2;
    lnk_valid = 1'b1; lnk_data = 32'h400;
    step(); // E0
    alu_valid = 1'b0; ld_valid = 1'b0; lnk_valid = 1'b0;
    n_vec++; if ({alu_ready, ld_ready, lnk_ready} !== 3'b001) begin n_err++; $display("FAIL all3_ready got %b want 001", {alu_ready, ld_ready, lnk_ready}); end
    step(); // E1: LNK
    n_vec++; if (WE_reg !== 1'b1 || ra_enable !== 1'b1 || rd_add !== 5'd31 || ra_data !== 32'h400 || rd_data !== 32'd0) begin
      n_err++; $display("FAIL all3_lnk we=%b ra_en=%b rd_add=%0d ra=%h rd=%h want 1/1/31/400/0", WE_reg, ra_enable, rd_add, ra_data, rd_data); end
    step(); // E2: LD
    n_vec++; if (WE_reg !== 1'b1 || ra_enable !== 1'b0 || rd_add !== 5'd4 || rd_data !== 32'hB2B2B2B2 || ra_data !== 32'd0) begin
      n_err++; $display("FAIL all3_ld we=%b ra_en=%b rd_add=%0d rd=%h ra=%h want 1/0/4/b2b2b2b2/0", WE_reg, ra_enable, rd_add, rd_data, ra_data); end
    step(); // E3: ALU
    n_vec++; if (WE_reg !== 1'b1 || ra_enable !== 1'b0 || rd_add !== 5'd3 || rd_data !== 32'hA1A1A1A1) begin
      n_err++; $display("FAIL all3_alu we=%b ra_en=%b rd_add=%0d rd=%h want 1/0/3/a1a1a1a1", WE_reg, ra_enable, rd_add, rd_data); end
    step(); // E4: idle
    n_vec++; if (WE_reg !== 1'b0) begin n_err++; $display("FAIL all3_idle we=%b want 0", WE_reg); end
  endtask

  task automatic test_aging();
    int exp_add [7];
    logic [31:0] exp_rd [7];
    exp_add = '{31, 31, 31, 31, 7, 9, 31};
    exp_rd  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h77, 32'h99, 32'h0};
    alu_valid = 1'b1; alu_add = 5'd9; alu_data = 32'h99;
    ld_valid = 1'b1;  ld_add = 5'd7;  ld_data = 32'h77;
    lnk_valid = 1'b1; lnk_data = 32'h800;
    step(); // E0
    alu_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      n_vec++; if (WE_reg !== 1'b1 || rd_add !== 5'(exp_add[k]) || rd_data !== exp_rd[k]) begin
        n_err++; $display("FAIL aging_e%0d we=%b rd_add=%0d rd=%h want 1/%0d/%h", k + 1, WE_reg, rd_add, rd_data, exp_add[k], exp_rd[k]); end
    end
    ld_valid = 1'b0; lnk_valid = 1'b0;
    repeat (4) step();
    n_vec++; if (WE_reg !== 1'b0 || {alu_ready, ld_ready, lnk_ready} !== 3'b111) begin n_err++; $display("FAIL aging_drain we=%b ready=%b want 0/111", WE_reg, {alu_ready, ld_ready, lnk_ready}); end
  endtask

  task automatic test_zero_write();
    alu_valid = 1'b1; alu_add = 5'd0; alu_data = 32'h12345678; rs_q = 5'd0;
    step(); // E0
    alu_valid = 1'b0;
    n_vec++; if (alu_ready !== 1'b1 || rs_pending !== 1'b0) begin n_err++; $display("FAIL zero_e0 ready=%b pend=%b want 1/0", alu_ready, rs_pending); end
    step(); // E1
    n_vec++; if (WE_reg !== 1'b0 || rs_pending !== 1'b0) begin n_err++; $display("FAIL zero_e1 we=%b pend=%b want 0/0", WE_reg, rs_pending); end
    step();
    n_vec++; if (WE_reg !== 1'b0 || alu_ready !== 1'b1) begin n_err++; $display("FAIL zero_e2 we=%b ready=%b want 0/1", WE_reg, alu_ready); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1; alu_add = 5'(k + 1); alu_data = 32'h1000_0000 + 32'(k);
      #1;
      n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d got %b want 1", k, alu_ready); end
      step();
      if (k > 0) begin
        n_vec++; if (WE_reg !== 1'b1 || rd_add !== 5'(k) || rd_data !== 32'h1000_0000 + 32'(k - 1)) begin
          n_err++; $display("FAIL b2b_out_%0d we=%b rd_add=%0d rd=%h want 1/%0d/%h", k - 1, WE_reg, rd_add, rd_data, k, 32'h1000_0000 + 32'(k - 1)); end
      end
    end
    alu_valid = 1'b0;
    step();
    n_vec++; if (WE_reg !== 1'b1 || rd_add !== 5'd8 || rd_data !== 32'h1000_0007) begin n_err++; $display("FAIL b2b_out_7 we=%b rd_add=%0d rd=%h want 1/8/10000007", WE_reg, rd_add, rd_data); end
    step();
    n_vec++; if (WE_reg !== 1'b0) begin n_err++; $display("FAIL b2b_idle we=%b want 0", WE_reg); end
  endtask

  task automatic test_mid_reset();
    alu_valid = 1'b1; alu_add = 5'd10; alu_data = 32'hAA;
    ld_valid = 1'b1;  ld_add = 5'd11;  ld_data = 32'hBB;
    lnk_valid = 1'b1; lnk_data = 32'hCC;
    step(); // E0
    alu_valid = 1'b0; ld_valid = 1'b0; lnk_valid = 1'b0;
    step(); // E1: LNK out, ALU/LD still held
    n_vec++; if (WE_reg !== 1'b1 || alu_ready !== 1'b0) begin n_err++; $display("FAIL mrst_pre we=%b alu_ready=%b want 1/0", WE_reg, alu_ready); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (WE_reg !== 1'b0 || ra_enable !== 1'b0 || {alu_ready, ld_ready, lnk_ready} !== 3'b111) begin
      n_err++; $display("FAIL mrst_now we=%b ra_en=%b ready=%b want 0/0/111", WE_reg, ra_enable, {alu_ready, ld_ready, lnk_ready}); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if (WE_reg !== 1'b0 || rd_add !== 5'd0) begin n_err++; $display("FAIL mrst_stale_%0d we=%b rd_add=%0d want 0/0", k, WE_reg, rd_add); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_all_three();
    test_aging();
    test_zero_write();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
